// File: rtl/data_sram_bridge_if.sv
// data_sram_bridge_if
//   Groups the CPU data-bus request/response signals and the data-SRAM
//   signals that pass through data_sram_bridge.
//   master : the CPU/RAM side (drives requests and RAM read data)
//   slave  : the bridge (decodes requests, drives RAM controls and read data)
//   Signals:
//     cpu_data_en/we/addr/wdata  CPU request (we == 0 means read)
//     cpu_data_rdata             read data, one cycle after the request
//     ram_en/we/addr/wdata       RAM controls, combinational pass-through
//     ram_rdata                  RAM read data, one-cycle latency
interface data_sram_bridge_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_data_en;
    logic [3:0]        cpu_data_we;
    logic [31:0]       cpu_data_addr;
    logic [31:0]       cpu_data_wdata;
    logic [31:0]       cpu_data_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output cpu_data_en, cpu_data_we, cpu_data_addr, cpu_data_wdata,
        input  cpu_data_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  cpu_data_en, cpu_data_we, cpu_data_addr, cpu_data_wdata,
        output cpu_data_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Splits CPU data accesses between the data SRAM and a small window of
//   configuration registers (LED, SWITCH, TIMER, COMPARE, STATUS, CTRL).
//   Accesses that hit the window never reach the RAM; read data from the
//   registers is returned with the same one-cycle latency as the RAM.
//   Ports:
//     clk        sole clock
//     reset      synchronous, active-high
//     bus        data_sram_bridge_if.slave (CPU request + RAM signals)
//     led        LED register value
//     switch     asynchronous switch inputs (synchronised internally)
//     timer_irq  level interrupt: pending & irq_en, straight from flops
module data_sram_bridge #(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
    parameter logic [31:0] CONF_MASK = 32'hFFFF_0000,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    data_sram_bridge_if.slave    bus,
    output logic [LED_W-1:0]     led,
    input  logic [SW_W-1:0]      switch,
    output logic                 timer_irq
);

    localparam logic [7:0] OFF_LED     = 8'h00;
    localparam logic [7:0] OFF_SWITCH  = 8'h04;
    localparam logic [7:0] OFF_TIMER   = 8'h08;
    localparam logic [7:0] OFF_COMPARE = 8'h0C;
    localparam logic [7:0] OFF_STATUS  = 8'h10;
    localparam logic [7:0] OFF_CTRL    = 8'h14;

    // Decode
    logic       conf_hit;
    logic       page_ok;
    logic       conf_rd;
    logic       conf_wr;
    logic [7:0] offset;

    assign conf_hit = bus.cpu_data_en && ((bus.cpu_data_addr & CONF_MASK) == CONF_BASE);
    assign offset   = bus.cpu_data_addr[7:0];
    // Only page 0 of the window holds registers; everything else reads as 0.
    assign page_ok  = (bus.cpu_data_addr[15:8] == 8'h00);
    assign conf_rd  = conf_hit && (bus.cpu_data_we == 4'b0000);
    assign conf_wr  = conf_hit && (bus.cpu_data_we != 4'b0000) && page_ok;

    // RAM pass-through
    assign bus.ram_en    = bus.cpu_data_en & ~conf_hit;
    assign bus.ram_we    = bus.ram_en ? bus.cpu_data_we : 4'b0000;
    assign bus.ram_addr  = bus.cpu_data_addr[ADDR_W+1:2];
    assign bus.ram_wdata = bus.cpu_data_wdata;

    // State
    logic [LED_W-1:0] led_reg,      led_next;
    logic [31:0]      timer_reg,    timer_next;
    logic [31:0]      compare_reg,  compare_next;
    logic             pending_reg,  pending_next;
    logic             irq_en_reg,   irq_en_next;
    logic             run_reg,      run_next;
    logic [SW_W-1:0]  sw_sync1_reg;
    logic [SW_W-1:0]  sw_sync2_reg;
    logic             sel_q;
    logic [31:0]      conf_rdata_q, conf_rdata_next;

    // Byte-enable mask and zero-extended register views
    logic [31:0] wmask;
    logic [31:0] led_ext;
    logic [31:0] sw_ext;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{bus.cpu_data_we[gi]}};
        end
        if (LED_W < 32) begin : g_led_pad
            assign led_ext = {{(32-LED_W){1'b0}}, led_reg};
        end else begin : g_led_full
            assign led_ext = led_reg;
        end
        if (SW_W < 32) begin : g_sw_pad
            assign sw_ext = {{(32-SW_W){1'b0}}, sw_sync2_reg};
        end else begin : g_sw_full
            assign sw_ext = sw_sync2_reg;
        end
    endgenerate

    logic [31:0] led_merged;
    logic [31:0] timer_merged;
    logic [31:0] compare_merged;

    assign led_merged     = (led_ext     & ~wmask) | (bus.cpu_data_wdata & wmask);
    // Merged onto the pre-increment value so a write fully defines the result.
    assign timer_merged   = (timer_reg   & ~wmask) | (bus.cpu_data_wdata & wmask);
    assign compare_merged = (compare_reg & ~wmask) | (bus.cpu_data_wdata & wmask);

    logic [31:0] rd_val;

    always_comb begin
        rd_val          = 32'h0;
        led_next        = led_reg;
        timer_next      = timer_reg;
        compare_next    = compare_reg;
        pending_next    = pending_reg;
        irq_en_next     = irq_en_reg;
        run_next        = run_reg;

        // Read mux uses current register values, so read data is
        // always the value before any same-cycle update.
        if (page_ok) begin
            case (offset)
                OFF_LED:     rd_val = led_ext;
                OFF_SWITCH:  rd_val = sw_ext;
                OFF_TIMER:   rd_val = timer_reg;
                OFF_COMPARE: rd_val = compare_reg;
                OFF_STATUS:  rd_val = {31'h0, pending_reg};
                OFF_CTRL:    rd_val = {30'h0, run_reg, irq_en_reg};
                default:     rd_val = 32'h0;
            endcase
        end
        conf_rdata_next = conf_rd ? rd_val : 32'h0;

        if (run_reg) begin
            timer_next = timer_reg + 32'd1;
        end

        // Clear first, then set, so a same-cycle match keeps pending high.
        if (conf_wr && (offset == OFF_STATUS) && bus.cpu_data_we[0] && bus.cpu_data_wdata[0]) begin
            pending_next = 1'b0;
        end
        if (run_reg && (timer_reg == compare_reg)) begin
            pending_next = 1'b1;
        end

        if (conf_wr) begin
            case (offset)
                OFF_LED:     led_next     = led_merged[LED_W-1:0];
                OFF_TIMER:   timer_next   = timer_merged;
                OFF_COMPARE: compare_next = compare_merged;
                OFF_CTRL: begin
                    if (bus.cpu_data_we[0]) begin
                        irq_en_next = bus.cpu_data_wdata[0];
                        run_next    = bus.cpu_data_wdata[1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg      <= '0;
            timer_reg    <= 32'h0;
            compare_reg  <= 32'hFFFF_FFFF;
            pending_reg  <= 1'b0;
            irq_en_reg   <= 1'b0;
            run_reg      <= 1'b1;
            sw_sync1_reg <= '0;
            sw_sync2_reg <= '0;
            sel_q        <= 1'b0;
            conf_rdata_q <= 32'h0;
        end else begin
            led_reg      <= led_next;
            timer_reg    <= timer_next;
            compare_reg  <= compare_next;
            pending_reg  <= pending_next;
            irq_en_reg   <= irq_en_next;
            run_reg      <= run_next;
            sw_sync1_reg <= switch;
            sw_sync2_reg <= sw_sync1_reg;
            sel_q        <= conf_hit;
            conf_rdata_q <= conf_rdata_next;
        end
    end

    // Forced to 0 while reset is held so a read interrupted by reset
    // never returns stale data.
    assign bus.cpu_data_rdata = reset ? 32'h0 : (sel_q ? conf_rdata_q : bus.ram_rdata);
    assign led       = led_reg;
    assign timer_irq = pending_reg & irq_en_reg;

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

    localparam logic [31:0] CONF = 32'hBFAF_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    data_sram_bridge_if #(.ADDR_W(16)) bus ();

    data_sram_bridge #(
        .ADDR_W(16), .CONF_BASE(32'hBFAF_0000), .CONF_MASK(32'hFFFF_0000),
        .LED_W(16), .SW_W(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .led(led), .switch(switch), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %-16s got %08h", name, act);
        end else begin
            $display("FAIL %-16s got %08h expected %08h", name, act, exp);
        end
    endfunction

    // Simple RAM model with one-cycle read latency
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.ram_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.ram_we[k]) mem[bus.ram_addr[7:0]][k*8 +: 8] <= bus.ram_wdata[k*8 +: 8];
            end
            if (bus.ram_we == 4'b0000) bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        end
    end

    // Scoreboard: expected read data pushed by the driver, popped by the monitor
    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    logic rd_issued_d;
    always @(posedge clk) begin
        rd_issued_d <= !reset && bus.cpu_data_en && (bus.cpu_data_we == 4'b0000);
    end

    always @(negedge clk) begin
        if (rd_issued_d === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_read", bus.cpu_data_rdata, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, bus.cpu_data_rdata, e.exp);
            end
        end
    end

    // Driver: drive one access for exactly one cycle (called at posedge+1)
    task automatic drive(input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input string name);
        exp_t e;
        bus.cpu_data_en    = 1'b1;
        bus.cpu_data_we    = we;
        bus.cpu_data_addr  = addr;
        bus.cpu_data_wdata = wdata;
        if (we == 4'b0000) begin
            e.name = name;
            e.exp  = exp_rd;
            sb_q.push_back(e);
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
        bus.cpu_data_en = 1'b0;
        bus.cpu_data_we = 4'b0000;
    endtask

    task automatic op(input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input string name);
        drive(we, addr, wdata, exp_rd, name);
        finish_cycle();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd, input string name);
        op(4'b0000, addr, 32'h0, exp_rd, name);
    endtask

    task automatic wr(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        op(we, addr, wdata, 32'h0, "write");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        switch             = 8'h00;
        bus.cpu_data_en    = 1'b0;
        bus.cpu_data_we    = 4'b0000;
        bus.cpu_data_addr  = 32'h0;
        bus.cpu_data_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_irq", {31'h0, timer_irq}, 32'h0);
        check("rst_rdata", bus.cpu_data_rdata, 32'h0);
        reset = 1'b0;

        // Reset state: timer starts at 0 and counts (run=1 out of reset)
        rd(CONF + 32'h08, 32'h0000_0000, "rst_timer0");
        rd(CONF + 32'h08, 32'h0000_0001, "rst_timer1");
        rd(CONF + 32'h0C, 32'hFFFF_FFFF, "rst_compare");
        rd(CONF + 32'h14, 32'h0000_0002, "rst_ctrl");
        rd(CONF + 32'h10, 32'h0000_0000, "rst_status");
        rd(CONF + 32'h04, 32'h0000_0000, "rst_switch");

        // RAM path
        drive(4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, "ram_wr");
        #1;
        check("ram_wr_en", {31'h0, bus.ram_en}, 32'h1);
        check("ram_wr_we", {28'h0, bus.ram_we}, 32'hF);
        finish_cycle();
        drive(4'b0000, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "ram_rd_data");
        #1;
        check("ram_rd_en", {31'h0, bus.ram_en}, 32'h1);
        check("ram_rd_addr", {16'h0, bus.ram_addr}, 32'h4);
        check("ram_rd_we", {28'h0, bus.ram_we}, 32'h0);
        finish_cycle();

        // LED byte writes
        drive(4'b0011, CONF, 32'h9999_0077, 32'h0, "led_wr");
        #1;
        check("conf_ram_en", {31'h0, bus.ram_en}, 32'h0);
        finish_cycle();
        check("led_0077", {16'h0, led}, 32'h0000_0077);
        wr(4'b0001, CONF, 32'h1234_ABCD);
        rd(CONF, 32'h0000_00CD, "led_rd_cd");
        check("led_00cd", {16'h0, led}, 32'h0000_00CD);
        wr(4'b0010, CONF, 32'h0000_3300);
        rd(CONF, 32'h0000_33CD, "led_rd_33cd");

        // Unmapped / out-of-page
        rd(CONF + 32'h40, 32'h0, "unmapped_40");
        rd(CONF + 32'h100, 32'h0, "page1_rd");
        wr(4'b1111, CONF + 32'h100, 32'h0000_FFFF);
        rd(CONF, 32'h0000_33CD, "page1_wr_ign");
        wr(4'b1111, CONF + 32'h04, 32'h0000_00FF);
        rd(CONF + 32'h04, 32'h0, "switch_ro");

        // Timer compare -> pending -> irq
        wr(4'b0001, CONF + 32'h14, 32'h0);
        wr(4'b1111, CONF + 32'h08, 32'h0);
        wr(4'b1111, CONF + 32'h0C, 32'd20);
        wr(4'b0001, CONF + 32'h14, 32'h3);
        wr(4'b1111, CONF + 32'h08, 32'd10);
        idle(10);
        check("irq_before", {31'h0, timer_irq}, 32'h0);
        idle(1);
        check("irq_at_11", {31'h0, timer_irq}, 32'h1);
        wr(4'b0001, CONF + 32'h10, 32'h1);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0);

        // Simultaneous match and W1C: set wins
        wr(4'b1111, CONF + 32'h0C, 32'd50);
        wr(4'b1111, CONF + 32'h08, 32'd45);
        idle(5);
        check("irq_pre_match", {31'h0, timer_irq}, 32'h0);
        wr(4'b0001, CONF + 32'h10, 32'h1);
        check("set_wins_irq", {31'h0, timer_irq}, 32'h1);
        rd(CONF + 32'h10, 32'h1, "set_wins_stat");
        wr(4'b0001, CONF + 32'h10, 32'h1);
        rd(CONF + 32'h10, 32'h0, "stat_cleared");

        // Wrap
        wr(4'b0001, CONF + 32'h14, 32'h2);
        wr(4'b1111, CONF + 32'h08, 32'hFFFF_FFFE);
        idle(1);
        rd(CONF + 32'h08, 32'hFFFF_FFFF, "timer_ffff");
        rd(CONF + 32'h08, 32'h0000_0000, "timer_wrap0");

        // run=0 holds timer
        wr(4'b0001, CONF + 32'h14, 32'h0);
        wr(4'b1111, CONF + 32'h08, 32'h0000_1234);
        rd(CONF + 32'h08, 32'h0000_1234, "hold_start");
        idle(100);
        rd(CONF + 32'h08, 32'h0000_1234, "hold_100");

        // Switch synchronizer
        switch = 8'hA5;
        idle(3);
        rd(CONF + 32'h04, 32'h0000_00A5, "switch_a5");

        // Reset in the cycle after a conf read: read is discarded
        drive(4'b0000, CONF, 32'h0, 32'h0, "rst_mid_read");
        @(posedge clk);
        #1;
        bus.cpu_data_en = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        rd(CONF, 32'h0, "led_after_rst");

        idle(3);
        check("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 Parameter ADDR_W, default 16, RAM word-address width; RAM address = cpu_data_addr[ADDR_W+1:2].
REQ-002 Parameter CONF_BASE, default 32'hBFAF_0000, base address of the config-register window.
REQ-003 Parameter CONF_MASK, default 32'hFFFF_0000, mask used for window decode.
REQ-004 Parameter LED_W, default 16, LED output width (1..32).
REQ-005 Parameter SW_W, default 8, switch input width (1..32).
REQ-006 clk  in  1  sole clock; all state updates on posedge clk.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cpu_data_en  in  1  CPU access request, one access per cycle.
REQ-009 cpu_data_we  in  4  byte write enables; 0 = read.
REQ-010 cpu_data_addr  in  32  byte address.
REQ-011 cpu_data_wdata  in  32  write data.
REQ-012 cpu_data_rdata  out  32  read data, valid the cycle after the request.
REQ-013 ram_en  out  1  RAM enable.
REQ-014 ram_we  out  4  RAM byte write enables.
REQ-015 ram_addr  out  ADDR_W  RAM word address.
REQ-016 ram_wdata  out  32  RAM write data.
REQ-017 ram_rdata  in  32  RAM read data, one-cycle latency.
REQ-018 led  out  LED_W  LED register value.
REQ-019 switch  in  SW_W  asynchronous switch inputs.
REQ-020 timer_irq  out  1  timer interrupt, level.

Function
REQ-021 conf_hit = cpu_data_en & ((cpu_data_addr & CONF_MASK) == CONF_BASE), combinational.
REQ-022 ram_en = cpu_data_en & ~conf_hit; ram_we = ram_en ? cpu_data_we : 0; ram_addr and ram_wdata pass through combinationally.
REQ-023 sel_q registers conf_hit each cycle; cpu_data_rdata = sel_q ? conf_rdata_q : ram_rdata.
REQ-024 conf_rdata_q captures the addressed register's value on a conf read; a conf write or idle cycle loads 0.
REQ-025 Read data is the register value before any same-cycle update, giving one-cycle latency identical to RAM.
REQ-026 Register map, offset = addr[7:0]: 0x00 LED (RW), 0x04 SWITCH (RO), 0x08 TIMER (RW), 0x0C COMPARE (RW), 0x10 STATUS (bit0 pending, W1C), 0x14 CTRL (bit0 irq_en, bit1 run).
REQ-027 Unmapped offsets, and window addresses with addr[15:8] != 0, read 0; writes to them are ignored.
REQ-028 Writes honour byte enables: byte k updates only when cpu_data_we[k]=1; bits above LED_W are ignored.
REQ-029 SWITCH is a 2-flop synchronizer output, zero-extended to 32 bits; writes to SWITCH are ignored.
REQ-030 TIMER increments by 1 each cycle while CTRL.run=1 and wraps from 32'hFFFF_FFFF to 0.
REQ-031 A TIMER write in the same cycle as an increment wins; the loaded value is byte-merged onto the pre-increment value.
REQ-032 STATUS.pending sets in the cycle after TIMER == COMPARE while run=1.
REQ-033 A W1C write to STATUS bit0 clears pending; if a set and a clear occur in the same cycle, set wins.
REQ-034 timer_irq = pending & CTRL.irq_en, driven from registers with no combinational path from inputs.
REQ-035 While run=0, TIMER holds its value and the compare match cannot set pending.

Reset
REQ-036 During reset: LED=0, TIMER=0, COMPARE=32'hFFFF_FFFF, pending=0, CTRL=2'b10 (run=1, irq_en=0), synchronizer=0, sel_q=0, conf_rdata_q=0.
REQ-037 While reset is high, cpu_data_rdata=0 and no register updates; ram_* outputs remain combinational pass-through.
REQ-038 Reset asserted mid-access discards the pending read; the first cycle after reset yields sel_q=0.

Verification
REQ-039 RAM path: read 0x0000_0010 -> ram_en=1, ram_addr=4, ram_we=0; next cycle rdata=ram_rdata; a write of we=4'b0011 to 0xBFAF_0000 -> ram_en=0.
REQ-040 LED byte write: write 0x1234_ABCD, we=4'b0001 to 0xBFAF_0000, then read -> rdata=0x0000_00CD, led=16'h00CD.
REQ-041 Timer/IRQ: CTRL=3, COMPARE=20, TIMER write 10 -> pending=1 and timer_irq=1 exactly 11 cycles after the write cycle; W1C on STATUS -> timer_irq=0 next cycle.
REQ-042 Simultaneous set/clear: W1C to STATUS in the same cycle as a compare match -> pending stays 1.
REQ-043 Wrap and run=0: TIMER=32'hFFFF_FFFE, run=1 -> reads ...FFFF then 0; with CTRL=0, TIMER stays constant across 100 cycles.
REQ-044 Switch/unmapped: switch=8'hA5 held 3 cycles -> SWITCH read 0x0000_00A5; a read at 0xBFAF_0040 -> 0; reset mid-read -> rdata=0.
